// File: rtl/alu_flags_pkg.sv
// Shared definitions for the ALU flags register and branch-condition decoder:
// flag bit positions, 4-bit condition codes and the packed flags type.
package alu_flags_pkg;

  typedef logic [4:0] flags_t;

  localparam int unsigned FLAG_O  = 0;
  localparam int unsigned FLAG_S  = 1;
  localparam int unsigned FLAG_Z  = 2;
  localparam int unsigned FLAG_CA = 3;
  localparam int unsigned FLAG_CL = 4;

  localparam logic [3:0] COND_O   = 4'd0;
  localparam logic [3:0] COND_NO  = 4'd1;
  localparam logic [3:0] COND_S   = 4'd2;
  localparam logic [3:0] COND_NS  = 4'd3;
  localparam logic [3:0] COND_Z   = 4'd4;
  localparam logic [3:0] COND_NZ  = 4'd5;
  localparam logic [3:0] COND_CA  = 4'd6;
  localparam logic [3:0] COND_NCA = 4'd7;
  localparam logic [3:0] COND_CL  = 4'd8;
  localparam logic [3:0] COND_NCL = 4'd9;
  localparam logic [3:0] COND_BE  = 4'd10;
  localparam logic [3:0] COND_A   = 4'd11;
  localparam logic [3:0] COND_L   = 4'd12;
  localparam logic [3:0] COND_GE  = 4'd13;
  localparam logic [3:0] COND_LE  = 4'd14;
  localparam logic [3:0] COND_G   = 4'd15;

endpackage

// File: rtl/alu_flags_register_cond_eval.sv
// Combinational branch-condition decoder: selects one of 16 conditions over
// the five architectural flags. Shared with the branch unit.
module flags_cond_eval
  import alu_flags_pkg::*;
(
  input  logic [3:0] cond_sel_i,
  input  flags_t     flags_i,
  output logic       cond_true_o
);

  logic o, s, z, ca, cl, lt;

  always_comb begin
    o  = flags_i[FLAG_O];
    s  = flags_i[FLAG_S];
    z  = flags_i[FLAG_Z];
    ca = flags_i[FLAG_CA];
    cl = flags_i[FLAG_CL];
    lt = s ^ o;
    cond_true_o = 1'b0;
    case (cond_sel_i)
      COND_O:   cond_true_o = o;
      COND_NO:  cond_true_o = !o;
      COND_S:   cond_true_o = s;
      COND_NS:  cond_true_o = !s;
      COND_Z:   cond_true_o = z;
      COND_NZ:  cond_true_o = !z;
      COND_CA:  cond_true_o = ca;
      COND_NCA: cond_true_o = !ca;
      COND_CL:  cond_true_o = cl;
      COND_NCL: cond_true_o = !cl;
      COND_BE:  cond_true_o = !ca || z;
      COND_A:   cond_true_o = ca && !z;
      COND_L:   cond_true_o = lt;
      COND_GE:  cond_true_o = !lt;
      COND_LE:  cond_true_o = z || lt;
      COND_G:   cond_true_o = !z && !lt;
      default:  cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flags_register.sv
// Architectural flags register with MainBus save/restore and branch condition
// output. Define FLAGS_SHADOW_STACK_EN to build the nested-interrupt shadow stack.
module alu_flags_register
  import alu_flags_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic       AluClock,
  input  logic       Reset,
  input  logic       Flags_0_Overflow,
  input  logic       Flags_1_Sign,
  input  logic       Flags_2_Zero,
  input  logic       Flags_3_CarryA,
  input  logic       Flags_4_CarryL,
  input  logic       FlagsLoad,
  input  logic       FlagsBusLoad,
  input  logic       Flags_Assert,
  inout  wire  [7:0] MainBus,
  input  logic [3:0] CondSel,
  output logic       CondTrue,
  output logic [4:0] FlagsQ,
  input  logic       Push,
  input  logic       Pop,
  output logic [3:0] StackDepth,
  output logic       StackOvf,
  output logic       StackUnf
);

  flags_t flags_q, flags_d, live_flags, load_val;
  logic   unused_bus_hi;

  assign live_flags = {Flags_4_CarryL, Flags_3_CarryA, Flags_2_Zero,
                       Flags_1_Sign, Flags_0_Overflow};
  assign unused_bus_hi = ^MainBus[7:5];

  always_comb begin
    load_val = flags_q;
    if (FlagsBusLoad)   load_val = MainBus[4:0];
    else if (FlagsLoad) load_val = live_flags;
  end

`ifdef FLAGS_SHADOW_STACK_EN
  localparam int unsigned IW = (STACK_DEPTH > 2) ? $clog2(STACK_DEPTH) : 1;

  flags_t          stack_q [STACK_DEPTH];
  flags_t          stack_d [STACK_DEPTH];
  logic [3:0]      depth_q, depth_d, top_full;
  logic [IW-1:0]   wr_idx, rd_idx;
  logic            ovf_q, ovf_d, unf_q, unf_d, empty, full;

  assign top_full = depth_q - 4'd1;
  assign wr_idx   = depth_q[IW-1:0];
  assign rd_idx   = top_full[IW-1:0];
  assign empty    = (depth_q == 4'd0);
  assign full     = (depth_q == 4'(STACK_DEPTH));

  // Push+Pop on a non-empty stack swaps FlagsQ with the top entry in place.
  always_comb begin
    flags_d = load_val;
    stack_d = stack_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (Push && Pop && !empty) begin
      flags_d         = stack_q[rd_idx];
      stack_d[rd_idx] = flags_q;
    end else if (Push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        stack_d[wr_idx] = flags_q;
        depth_d         = depth_q + 4'd1;
      end
    end else if (Pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        flags_d = stack_q[rd_idx];
        depth_d = top_full;
      end
    end
  end

  always_ff @(posedge AluClock or posedge Reset) begin
    if (Reset) begin
      stack_q <= '{default: '0};
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      stack_q <= stack_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign StackDepth = depth_q;
  assign StackOvf   = ovf_q;
  assign StackUnf   = unf_q;
`else
  logic unused_stack_ctl;

  assign unused_stack_ctl = Push ^ Pop;
  assign flags_d    = load_val;
  assign StackDepth = '0;
  assign StackOvf   = 1'b0;
  assign StackUnf   = 1'b0;
`endif

  always_ff @(posedge AluClock or posedge Reset) begin
    if (Reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign FlagsQ  = flags_q;
  assign MainBus = Flags_Assert ? 8'bzzzz_zzzz : {3'b000, flags_q};

  flags_cond_eval u_cond (
    .cond_sel_i  (CondSel),
    .flags_i     (flags_q),
    .cond_true_o (CondTrue)
  );

endmodule

// File: tb/tb_alu_flags_register.sv
// Directed self-checking bench for alu_flags_register; stack vectors run only
// when FLAGS_SHADOW_STACK_EN is defined.
module tb_alu_flags_register;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fo = 1'b0, fs = 1'b0, fz = 1'b0, fca = 1'b0, fcl = 1'b0;
  logic       fload = 1'b0, fbload = 1'b0, fassert = 1'b1;
  logic [3:0] csel = '0;
  logic       push = 1'b0, pop = 1'b0;
  logic       cond_true, ovf, unf;
  logic [4:0] flags_q;
  logic [3:0] depth;
  logic [7:0] bus_drv = '0;
  logic       bus_oe = 1'b0;
  wire  [7:0] MainBus;

  int checks = 0;
  int errors = 0;

  assign MainBus = bus_oe ? bus_drv : 8'bzzzz_zzzz;

  always #5 clk = ~clk;

  alu_flags_register #(.STACK_DEPTH(4)) dut (
    .AluClock         (clk),
    .Reset            (rst),
    .Flags_0_Overflow (fo),
    .Flags_1_Sign     (fs),
    .Flags_2_Zero     (fz),
    .Flags_3_CarryA   (fca),
    .Flags_4_CarryL   (fcl),
    .FlagsLoad        (fload),
    .FlagsBusLoad     (fbload),
    .Flags_Assert     (fassert),
    .MainBus          (MainBus),
    .CondSel          (csel),
    .CondTrue         (cond_true),
    .FlagsQ           (flags_q),
    .Push             (push),
    .Pop              (pop),
    .StackDepth       (depth),
    .StackOvf         (ovf),
    .StackUnf         (unf)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_live(input logic [4:0] v);
    {fcl, fca, fz, fs, fo} = v;
  endtask

  task automatic cond(input string tag, input logic [3:0] sel, input logic exp);
    csel = sel;
    #1;
    check(tag, {7'd0, cond_true}, {7'd0, exp});
  endtask

  task automatic idle();
    fload = 1'b0; fbload = 1'b0; push = 1'b0; pop = 1'b0; bus_oe = 1'b0;
  endtask

  task automatic bus_load(input logic [7:0] v, input logic p);
    bus_drv = v; bus_oe = 1'b1; fbload = 1'b1; push = p;
    tick();
    idle();
  endtask

  always @(negedge clk)
    if (!fassert && fbload) check("illegal_assert_busload", 8'd1, 8'd0);

  initial begin
    #2;
    check("rst_flags", {3'd0, flags_q}, 8'h00);
    check("rst_depth", {4'd0, depth}, 8'h00);
    check("rst_ovf", {7'd0, ovf}, 8'h00);
    check("rst_unf", {7'd0, unf}, 8'h00);
    cond("rst_cond_O", 4'd0, 1'b0);
    cond("rst_cond_NO", 4'd1, 1'b1);
    #3 rst = 1'b0;

    // O=1 S=0 Z=0 CA=1 CL=0
    set_live(5'b01001); fload = 1'b1;
    tick(); idle();
    check("load_live", {3'd0, flags_q}, 8'h09);
    cond("cond_CA", 4'd6, 1'b1);
    cond("cond_A", 4'd11, 1'b1);
    cond("cond_L", 4'd12, 1'b1);
    cond("cond_Z", 4'd4, 1'b0);
    cond("cond_BE", 4'd10, 1'b0);
    cond("cond_GE", 4'd13, 1'b0);
    cond("cond_LE", 4'd14, 1'b1);
    cond("cond_G", 4'd15, 1'b0);
    cond("cond_NCL", 4'd9, 1'b1);

    set_live(5'b10100); fload = 1'b1;
    tick(); idle();
    check("load_live2", {3'd0, flags_q}, 8'h14);
    fassert = 1'b0; #1;
    check("bus_assert", MainBus, 8'h14);
    fassert = 1'b1; #1;
    bus_drv = 8'hA5; bus_oe = 1'b1; #1;
    check("bus_release", MainBus, 8'hA5);
    bus_oe = 1'b0;
    bus_load(8'hFF, 1'b0);
    check("bus_load_ff", {3'd0, flags_q}, 8'h1F);
    cond("cond_G_all1", 4'd15, 1'b0);
    cond("cond_BE_all1", 4'd10, 1'b1);
    cond("cond_CL_all1", 4'd8, 1'b1);

    set_live(5'b00000); fload = 1'b1;
    bus_load(8'h04, 1'b0);
    check("bus_over_live", {3'd0, flags_q}, 8'h04);
    set_live(5'b11011);
    tick();
    check("hold", {3'd0, flags_q}, 8'h04);

`ifdef FLAGS_SHADOW_STACK_EN
    bus_load(8'h01, 1'b0);
    bus_load(8'h02, 1'b1);
    bus_load(8'h04, 1'b1);
    bus_load(8'h08, 1'b1);
    bus_load(8'h10, 1'b1);
    check("push4_depth", {4'd0, depth}, 8'h04);
    check("push4_flags", {3'd0, flags_q}, 8'h10);
    check("push4_ovf", {7'd0, ovf}, 8'h00);
    push = 1'b1; tick(); idle();
    check("push5_depth", {4'd0, depth}, 8'h04);
    check("push5_ovf", {7'd0, ovf}, 8'h01);
    check("push5_flags", {3'd0, flags_q}, 8'h10);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_v;
      exp_v = 8'h08 >> i;
      pop = 1'b1; tick(); idle();
      check($sformatf("pop%0d_flags", i), {3'd0, flags_q}, exp_v);
      check($sformatf("pop%0d_depth", i), {4'd0, depth}, 8'(3 - i));
    end
    pop = 1'b1; tick(); idle();
    check("pop5_unf", {7'd0, unf}, 8'h01);
    check("pop5_flags", {3'd0, flags_q}, 8'h01);
    check("ovf_sticky", {7'd0, ovf}, 8'h01);

    // Pop wins over a simultaneous bus load
    bus_load(8'h0C, 1'b1);
    bus_drv = 8'h1E; bus_oe = 1'b1; fbload = 1'b1; pop = 1'b1;
    tick(); idle();
    check("pop_over_bus", {3'd0, flags_q}, 8'h01);

    bus_load(8'h01, 1'b0);
    bus_load(8'h02, 1'b1);
    push = 1'b1; pop = 1'b1; tick(); idle();
    check("swap_flags", {3'd0, flags_q}, 8'h01);
    check("swap_depth", {4'd0, depth}, 8'h01);
    pop = 1'b1; tick(); idle();
    check("swap_top", {3'd0, flags_q}, 8'h02);
    check("swap_pop_depth", {4'd0, depth}, 8'h00);

    push = 1'b1; pop = 1'b1; tick(); idle();
    check("pushpop_empty_depth", {4'd0, depth}, 8'h01);
    push = 1'b1; tick(); push = 1'b1; tick(); idle();
    check("pre_rst_depth", {4'd0, depth}, 8'h03);
`else
    push = 1'b1; tick(); idle();
    check("noen_push_depth", {4'd0, depth}, 8'h00);
    check("noen_push_ovf", {7'd0, ovf}, 8'h00);
    set_live(5'b00011); fload = 1'b1; pop = 1'b1;
    tick(); idle();
    check("noen_pop_ignored", {3'd0, flags_q}, 8'h03);
    check("noen_pop_unf", {7'd0, unf}, 8'h00);
`endif

    #2 rst = 1'b1;
    #1;
    check("async_rst_flags", {3'd0, flags_q}, 8'h00);
    check("async_rst_depth", {4'd0, depth}, 8'h00);
    check("async_rst_ovf", {7'd0, ovf}, 8'h00);
    check("async_rst_unf", {7'd0, unf}, 8'h00);
    #1 rst = 1'b0;
    set_live(5'b00110); fload = 1'b1;
    tick(); idle();
    check("post_rst_load", {3'd0, flags_q}, 8'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_flags_register.md
# alu_flags_register

Architectural flags register on the consuming side of the ALU output stage: captures the five ALU flags (Overflow, Sign, Zero, CarryA, CarryL), holds them for branch-condition evaluation, and transfers them to and from MainBus for software save/restore. An optional shadow stack preserves flags across nested interrupts. Sits between the ALU result stage and the jump/branch control logic, on AluClock.

## Interface
Parameters:
- STACK_DEPTH, 4, number of shadow-stack entries (2..8); only meaningful with FLAGS_SHADOW_STACK_EN.

Ports:
- AluClock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Flags_0_Overflow, Flags_1_Sign, Flags_2_Zero, Flags_3_CarryA, Flags_4_CarryL  in  1 each  live flags from ALU output stage.
- FlagsLoad  in  1  capture live ALU flags at the next edge.
- FlagsBusLoad  in  1  capture MainBus[4:0] at the next edge.
- Flags_Assert  in  1  active low; drive flags onto MainBus.
- MainBus  inout  8  shared bus; driven {3'b000, FlagsQ} when Flags_Assert=0, else Z.
- CondSel  in  4  branch condition select.
- CondTrue  out  1  selected condition evaluated on FlagsQ.
- FlagsQ  out  5  registered flags, bit i = Flags_i.
- Push, Pop  in  1 each  shadow-stack controls.
- StackDepth  out  4  current stack occupancy.
- StackOvf, StackUnf  out  1 each  sticky push-when-full / pop-when-empty errors.

## Operation
- Reset values: FlagsQ=0, StackDepth=0, StackOvf=0, StackUnf=0, stack entries=0; CondTrue follows FlagsQ=0 through the decoder; MainBus is tri-stated unless Flags_Assert=0.
- FlagsQ update priority, highest first: Pop (stack non-empty) > FlagsBusLoad > FlagsLoad > hold.
- Push stores the pre-edge FlagsQ onto the stack top. It may coincide with FlagsLoad/FlagsBusLoad; the old value is pushed and the new value is loaded.
- Push and Pop together with depth>0: swap. FlagsQ takes the top entry, the top entry takes the old FlagsQ, depth is unchanged. With depth=0, treated as Push only.
- Push at depth=STACK_DEPTH: no stack change, StackOvf set. Pop at depth=0: FlagsQ per the remaining priority, StackUnf set. Both flags are sticky until Reset.
- Flags_Assert=0 with FlagsBusLoad=1 in the same cycle is illegal. The bench flags it; the RTL loads the driven value (self-loop, no change).
- CondSel decode (CA=CarryA, CL=CarryL, O, S, Z):
  - 0 O; 1 !O; 2 S; 3 !S; 4 Z; 5 !Z; 6 CA; 7 !CA; 8 CL; 9 !CL
  - 10 !CA|Z (unsigned ≤); 11 CA&!Z (unsigned >)
  - 12 S^O (signed <); 13 !(S^O) (signed ≥); 14 Z|(S^O) (signed ≤); 15 !Z&!(S^O) (signed >)

## Timing
- FlagsLoad/FlagsBusLoad sampled at edge N; FlagsQ and CondTrue reflect the new value after edge N (one-cycle latency).
- CondTrue is combinational from FlagsQ and CondSel; no extra register.
- MainBus drive and release are combinational on Flags_Assert, with the same tri-state behaviour as other bus assertors.
- Push/Pop: StackDepth updates at the same edge; a popped value is visible on FlagsQ after that edge.
- Reset asserted mid-operation clears everything asynchronously; the first edge after deassertion behaves as from reset.

## Configuration
- FLAGS_SHADOW_STACK_EN defined: stack of STACK_DEPTH entries, Push/Pop/StackDepth/StackOvf/StackUnf fully functional.
- Not defined: no stack storage. Push/Pop are ignored, and Pop does not affect FlagsQ priority. StackDepth, StackOvf and StackUnf are tied to 0.

## Structure
- Package alu_flags_pkg holds:
  - flag bit index constants (FLAG_O=0 … FLAG_CL=4)
  - 4-bit condition-code constants (COND_O … COND_G)
  - a flags_t 5-bit typedef
- One sub-module, flags_cond_eval: purely combinational CondSel/flags → CondTrue decoder, reused by the branch unit.

## Test plan
- Reset, then FlagsLoad with live flags O=1,S=0,Z=0,CA=1,CL=0 → FlagsQ=5'b01001 next cycle. CondSel=6 → CondTrue=1. CondSel=11 → CondTrue=1. CondSel=12 → CondTrue=1.
- Flags_Assert=0 with FlagsQ=5'b10100 → MainBus=8'h14. Release → Z. FlagsBusLoad with MainBus=8'hFF → FlagsQ=5'b11111.
- FlagsLoad and FlagsBusLoad in the same cycle (bus=8'h04, live all 0) → FlagsQ=5'b00100.
- (EN) Push ×4 with distinct values, then a 5th push → StackDepth=4, StackOvf=1. Pop ×4 → values return in LIFO order. 5th pop → StackUnf=1, FlagsQ unchanged.
- (EN) Depth 1 with top 5'b00001 and FlagsQ 5'b00010, Push+Pop → FlagsQ=5'b00001, top=5'b00010, depth 1.
- Reset asserted between edges while depth=3 → FlagsQ=0, StackDepth=0 and errors cleared immediately, without waiting for a clock edge.
